// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - EX/MEM and MEM/WB field layout, Mem_Con encodings and FSM states
package mem_stage_pkg;

    localparam int XLEN  = 32;
    localparam int RS_W  = 2;
    localparam int RD_W  = 5;
    localparam int EXM_W = 141;
    localparam int WB_W  = 104;

    localparam int EXM_PC_LSB     = 109;
    localparam int EXM_RS_LSB     = 107;
    localparam int EXM_PCSRC      = 106;
    localparam int EXM_REGCON     = 105;
    localparam int EXM_MEMCON_LSB = 103;
    localparam int EXM_BRANCH     = 102;
    localparam int EXM_SUM_LSB    = 70;
    localparam int EXM_ZERO       = 69;
    localparam int EXM_ALU_LSB    = 37;
    localparam int EXM_D2_LSB     = 5;
    localparam int EXM_RD_LSB     = 0;

    localparam int WB_RD_LSB    = 0;
    localparam int WB_ALU_LSB   = 5;
    localparam int WB_RDATA_LSB = 37;
    localparam int WB_REGCON    = 69;
    localparam int WB_RS_LSB    = 70;
    localparam int WB_PC_LSB    = 72;

    typedef enum logic [1:0] {
        MC_NONE  = 2'b00,
        MC_STORE = 2'b01,
        MC_LOAD  = 2'b10,
        MC_RSVD  = 2'b11
    } mem_con_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wb_pack.sv
// rtl/mem_wb_pack.sv - assembles the 104-bit MEM/WB word, all-zero when bubble is set
module mem_wb_pack
    import mem_stage_pkg::*;
(
    input  logic              bubble,
    input  logic [XLEN-1:0]   pc,
    input  logic [RS_W-1:0]   result_src,
    input  logic              reg_con,
    input  logic [XLEN-1:0]   read_data,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [RD_W-1:0]   rd,
    output logic [WB_W-1:0]   word
);

    always_comb begin
        word = '0;
        if (!bubble) begin
            word[WB_PC_LSB    +: XLEN] = pc;
            word[WB_RS_LSB    +: RS_W] = result_src;
            word[WB_REGCON]            = reg_con;
            word[WB_RDATA_LSB +: XLEN] = read_data;
            word[WB_ALU_LSB   +: XLEN] = alu_result;
            word[WB_RD_LSB    +: RD_W] = rd;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage with data-memory handshake; MEM_STAGE_MISALIGN_CHK_EN adds alignment checking
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [EXM_W-1:0]  EX_MEM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              stall,
    output logic              branch_taken,
    output logic [XLEN-1:0]   branch_target,
    output logic [WB_W-1:0]   MEM_WB
`ifdef MEM_STAGE_MISALIGN_CHK_EN
    ,
    output logic              misalign
`endif
);

    state_e          state, state_next;
    mem_con_e        mem_con;
    logic            is_load, is_store, bad_align, issue, bubble;
    logic [XLEN-1:0] alu_result, read_data;
    logic [WB_W-1:0] wb_next;

    assign mem_con    = mem_con_e'(EX_MEM[EXM_MEMCON_LSB +: 2]);
    assign is_load    = (mem_con == MC_LOAD);
    assign is_store   = (mem_con == MC_STORE);
    assign alu_result = EX_MEM[EXM_ALU_LSB +: XLEN];

`ifdef MEM_STAGE_MISALIGN_CHK_EN
    assign bad_align = (is_load | is_store) & (alu_result[1:0] != 2'b00);
`else
    assign bad_align = 1'b0;
`endif

    assign issue = (is_load | is_store) & ~bad_align;

    assign branch_taken  = EX_MEM[EXM_PCSRC] | (EX_MEM[EXM_BRANCH] & EX_MEM[EXM_ZERO]);
    assign branch_target = EX_MEM[EXM_SUM_LSB +: XLEN];
    assign dmem_addr     = alu_result;
    assign dmem_wdata    = EX_MEM[EXM_D2_LSB +: XLEN];

    always_comb begin
        state_next = state;
        dmem_req   = 1'b0;
        case (state)
            IDLE: begin
                dmem_req = issue;
                if (issue && !dmem_ack) state_next = WAIT;
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // reset is asynchronous, so the request must also drop combinationally
        if (!rst) begin
            dmem_req   = 1'b0;
            state_next = IDLE;
        end
    end

    assign dmem_we   = dmem_req & is_store;
    assign stall     = dmem_req & ~dmem_ack;
    assign bubble    = stall | bad_align;
    assign read_data = (dmem_req & dmem_ack & is_load) ? dmem_rdata : '0;

    mem_wb_pack u_pack (
        .bubble     (bubble),
        .pc         (EX_MEM[EXM_PC_LSB +: XLEN]),
        .result_src (EX_MEM[EXM_RS_LSB +: RS_W]),
        .reg_con    (EX_MEM[EXM_REGCON]),
        .read_data  (read_data),
        .alu_result (alu_result),
        .rd         (EX_MEM[EXM_RD_LSB +: RD_W]),
        .word       (wb_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            MEM_WB <= '0;
        end else begin
            state  <= state_next;
            MEM_WB <= wb_next;
        end
    end

`ifdef MEM_STAGE_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           misalign <= 1'b0;
        else if (bad_align) misalign <= 1'b1;
    end
`endif

endmodule
